// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared state encoding and BCD limits for the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_DEC  = 4'd9;
  localparam logic [3:0] BCD_MAX_SEXA = 4'd5;

  function automatic bit digit_ok(input int value, input int max);
    return (value >= 0) && (value <= max);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_down.sv
// ============================================================================
// Module      : bcd_digit_down
// Description : One down-counting BCD digit that wraps 0 -> MAX and borrows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_down #(
  parameter logic [3:0] MAX     = 4'd9,
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec_en) begin
      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec_en & (q_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module      : bcd_countdown_timer
// Description : MM:SS BCD countdown with prescaler, start/pause/load control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int INIT_MIN_T = 0,
  parameter int INIT_MIN_U = 2,
  parameter int INIT_SEC_T = 0,
  parameter int INIT_SEC_U = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       expired,
  output logic       tick
);

  localparam int             DIV       = CLK_FREQ / TICK_HZ;
  localparam int             PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(DIV - 1);
  localparam logic [3:0]     C_MIN_T   = 4'(INIT_MIN_T);
  localparam logic [3:0]     C_MIN_U   = 4'(INIT_MIN_U);
  localparam logic [3:0]     C_SEC_T   = 4'(INIT_SEC_T);
  localparam logic [3:0]     C_SEC_U   = 4'(INIT_SEC_U);
  localparam logic           INIT_ZERO = (INIT_MIN_T == 0) && (INIT_MIN_U == 0) &&
                                         (INIT_SEC_T == 0) && (INIT_SEC_U == 0);

  if (!digit_ok(INIT_MIN_T, int'(BCD_MAX_DEC)) || !digit_ok(INIT_MIN_U, int'(BCD_MAX_DEC)) ||
      !digit_ok(INIT_SEC_T, int'(BCD_MAX_SEXA)) || !digit_ok(INIT_SEC_U, int'(BCD_MAX_DEC)))
  begin : g_bad_init
    $error("bcd_countdown_timer: INIT_* reload digits are not a legal MM:SS BCD value");
  end

  if (DIV < 2) begin : g_bad_div
    $error("bcd_countdown_timer: CLK_FREQ/TICK_HZ must be at least 2");
  end

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          running_q;
  logic          expired_q;

  logic dec_en;
  logic borrow_su, borrow_st, borrow_mu, borrow_mt;
  logic at_one;

  assign dec_en = (state_q == ST_RUN) && (pre_q == PRE_LAST) && !load;
  assign at_one = ({min_t, min_u, sec_t, sec_u} == 16'h0001);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      pre_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = INIT_ZERO ? ST_DONE : ST_RUN;
            pre_d   = '0;
          end
        end
        ST_RUN: begin
          // The terminal-count decrement always lands, even under pause.
          if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (at_one || borrow_mt) begin
              state_d = ST_DONE;
            end else if (pause && !start) begin
              state_d = ST_PAUSED;
            end
          end else if (pause && !start) begin
            state_d = ST_PAUSED;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        ST_PAUSED: begin
          if (start && !pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          pre_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
    end
  end

  bcd_digit_down #(.MAX(BCD_MAX_DEC), .RST_VAL(C_SEC_U)) u_sec_u (
    .clk(clk), .rst(reset), .dec_en(dec_en), .load(load), .load_val(C_SEC_U),
    .q(sec_u), .borrow_out(borrow_su)
  );

  bcd_digit_down #(.MAX(BCD_MAX_SEXA), .RST_VAL(C_SEC_T)) u_sec_t (
    .clk(clk), .rst(reset), .dec_en(borrow_su), .load(load), .load_val(C_SEC_T),
    .q(sec_t), .borrow_out(borrow_st)
  );

  bcd_digit_down #(.MAX(BCD_MAX_DEC), .RST_VAL(C_MIN_U)) u_min_u (
    .clk(clk), .rst(reset), .dec_en(borrow_st), .load(load), .load_val(C_MIN_U),
    .q(min_u), .borrow_out(borrow_mu)
  );

  // A borrow out of the top digit means an underflow; it forces DONE as a guard.
  bcd_digit_down #(.MAX(BCD_MAX_DEC), .RST_VAL(C_MIN_T)) u_min_t (
    .clk(clk), .rst(reset), .dec_en(borrow_mu), .load(load), .load_val(C_MIN_T),
    .q(min_t), .borrow_out(borrow_mt)
  );

  assign running = running_q;
  assign expired = expired_q;
  assign tick    = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// Module      : tb_bcd_countdown_timer
// Description : Directed bench for bcd_countdown_timer (DIV = 10), three INIT sets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic load  = 1'b0;

  logic [3:0] a_mt, a_mu, a_st, a_su, b_mt, b_mu, b_st, b_su, c_mt, c_mu, c_st, c_su;
  logic a_run, a_exp, a_tick, b_run, b_exp, b_tick, c_run, c_exp, c_tick;
  logic [15:0] a_dig, b_dig, c_dig;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign a_dig = {a_mt, a_mu, a_st, a_su};
  assign b_dig = {b_mt, b_mu, b_st, b_su};
  assign c_dig = {c_mt, c_mu, c_st, c_su};

  bcd_countdown_timer #(.CLK_FREQ(10), .TICK_HZ(1), .INIT_MIN_T(0), .INIT_MIN_U(0),
                        .INIT_SEC_T(1), .INIT_SEC_U(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .min_t(a_mt), .min_u(a_mu), .sec_t(a_st), .sec_u(a_su),
    .running(a_run), .expired(a_exp), .tick(a_tick)
  );

  bcd_countdown_timer #(.CLK_FREQ(10), .TICK_HZ(1), .INIT_MIN_T(0), .INIT_MIN_U(1),
                        .INIT_SEC_T(0), .INIT_SEC_U(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .min_t(b_mt), .min_u(b_mu), .sec_t(b_st), .sec_u(b_su),
    .running(b_run), .expired(b_exp), .tick(b_tick)
  );

  bcd_countdown_timer #(.CLK_FREQ(10), .TICK_HZ(1), .INIT_MIN_T(0), .INIT_MIN_U(0),
                        .INIT_SEC_T(0), .INIT_SEC_U(0)) u_dut_c (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .min_t(c_mt), .min_u(c_mu), .sec_t(c_st), .sec_u(c_su),
    .running(c_run), .expired(c_exp), .tick(c_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    n_cmp++;
    if ({a_dig, a_run, a_exp, a_tick} !== {16'h0012, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_a: got digits=%h run/exp/tick=%b%b%b want 0012 000", a_dig, a_run, a_exp, a_tick);
    end
    n_cmp++;
    if ({c_dig, c_run, c_exp, c_tick} !== {16'h0000, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_c: got digits=%h run/exp/tick=%b%b%b want 0000 000", c_dig, c_run, c_exp, c_tick);
    end
  endtask

  task automatic test_countdown();
    logic seen;
    pulse_start();
    n_cmp++;
    if (a_run !== 1'b1) begin
      n_bad++;
      $display("FAIL cd_running: got %b want 1", a_run);
    end
    seen = 1'b0;
    repeat (9) begin
      step();
      if (a_tick) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL cd_early_tick: got tick before cycle 10, want none");
    end
    step();
    n_cmp++;
    if ({a_tick, a_dig} !== {1'b1, 16'h0011}) begin
      n_bad++;
      $display("FAIL cd_first_tick: got tick=%b digits=%h want tick=1 0011", a_tick, a_dig);
    end
    repeat (109) step();
    n_cmp++;
    if ({a_dig, a_run, a_exp} !== {16'h0001, 2'b10}) begin
      n_bad++;
      $display("FAIL cd_before_zero: got digits=%h run=%b exp=%b want 0001 1 0", a_dig, a_run, a_exp);
    end
    step();
    n_cmp++;
    if ({a_dig, a_run, a_exp, a_tick} !== {16'h0000, 3'b011}) begin
      n_bad++;
      $display("FAIL cd_zero: got digits=%h run/exp/tick=%b%b%b want 0000 011", a_dig, a_run, a_exp, a_tick);
    end
    step();
    n_cmp++;
    if ({a_dig, a_tick} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL cd_after_zero: got digits=%h tick=%b want 0000 0", a_dig, a_tick);
    end
  endtask

  task automatic test_done_hold();
    logic bad;
    bad = 1'b0;
    start = 1'b1;
    repeat (30) begin
      step();
      if ({a_dig, a_run, a_exp, a_tick} !== {16'h0000, 3'b010}) bad = 1'b1;
    end
    start = 1'b0;
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL done_hold: got state change in DONE (digits=%h exp=%b), want 0000 exp=1", a_dig, a_exp);
    end
    pulse_load();
    n_cmp++;
    if ({a_dig, a_run, a_exp, a_tick} !== {16'h0012, 3'b000}) begin
      n_bad++;
      $display("FAIL done_load: got digits=%h run/exp/tick=%b%b%b want 0012 000", a_dig, a_run, a_exp, a_tick);
    end
    bad = 1'b0;
    repeat (15) begin
      step();
      if (a_tick || a_run || a_dig !== 16'h0012) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: got activity in IDLE (digits=%h), want 0012 idle", a_dig);
    end
  endtask

  task automatic test_borrow();
    pulse_load();
    pulse_start();
    repeat (10) step();
    n_cmp++;
    if ({b_dig, b_tick, b_run} !== {16'h0059, 2'b11}) begin
      n_bad++;
      $display("FAIL borrow_0059: got digits=%h tick=%b run=%b want 0059 1 1", b_dig, b_tick, b_run);
    end
    step();
    n_cmp++;
    if ({b_dig, b_tick} !== {16'h0059, 1'b0}) begin
      n_bad++;
      $display("FAIL borrow_tick_width: got digits=%h tick=%b want 0059 0", b_dig, b_tick);
    end
  endtask

  task automatic test_pause();
    logic seen;
    pulse_load();
    pulse_start();
    repeat (4) step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    n_cmp++;
    if (a_run !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_enter: got running=%b want 0", a_run);
    end
    seen = 1'b0;
    repeat (49) begin
      step();
      if (a_tick || a_dig !== 16'h0012) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_hold: got change while paused (digits=%h), want 0012 no tick", a_dig);
    end
    pulse_start();
    n_cmp++;
    if (a_run !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_resume: got running=%b want 1", a_run);
    end
    seen = 1'b0;
    repeat (5) begin
      step();
      if (a_tick) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_early: got tick before 6 cycles after resume, want none");
    end
    step();
    n_cmp++;
    if ({a_tick, a_dig} !== {1'b1, 16'h0011}) begin
      n_bad++;
      $display("FAIL resume_tick: got tick=%b digits=%h want 1 0011", a_tick, a_dig);
    end
  endtask

  task automatic test_async_reset();
    pulse_load();
    pulse_start();
    repeat (50) step();
    n_cmp++;
    if ({a_dig, a_tick} !== {16'h0007, 1'b1}) begin
      n_bad++;
      $display("FAIL ar_pre: got digits=%h tick=%b want 0007 1", a_dig, a_tick);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_dig, a_run, a_exp, a_tick} !== {16'h0012, 3'b000}) begin
      n_bad++;
      $display("FAIL ar_immediate: got digits=%h run/exp/tick=%b%b%b want 0012 000", a_dig, a_run, a_exp, a_tick);
    end
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({a_dig, a_run, a_tick} !== {16'h0012, 2'b00}) begin
      n_bad++;
      $display("FAIL ar_idle: got digits=%h run=%b tick=%b want 0012 0 0", a_dig, a_run, a_tick);
    end
  endtask

  task automatic test_zero_init();
    logic bad;
    pulse_load();
    n_cmp++;
    if (c_exp !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_loaded: got expired=%b want 0", c_exp);
    end
    pulse_start();
    n_cmp++;
    if ({c_dig, c_run, c_exp, c_tick} !== {16'h0000, 3'b010}) begin
      n_bad++;
      $display("FAIL zero_start: got digits=%h run/exp/tick=%b%b%b want 0000 010", c_dig, c_run, c_exp, c_tick);
    end
    bad = 1'b0;
    repeat (15) begin
      step();
      if (c_tick || !c_exp || c_dig !== 16'h0000) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_hold: got tick or change after zero start (digits=%h), want 0000 exp=1", c_dig);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_done_hold();
    test_borrow();
    test_pause();
    test_async_reset();
    test_zero_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
